// File: rtl/seg_bus_writer.sv
// seg_bus_writer
// Host-side driver for an 8-digit segment register reached over an 8-bit
// command bus {position[2:0], load, data[3:0]}. A 32-bit hex word accepted
// over valid/ready is written one nibble per cycle, and only the nibbles that
// changed are sent. While no write is in progress, load=0 read cycles walk
// positions 0..7. Each returned segment byte is latched together with a
// one-hot digit select, which drives a multiplexed display.
module seg_bus_writer #(
    parameter int unsigned SCAN_DIV       = 4,    // cycles per scan position, 2..255
    parameter bit          SKIP_UNCHANGED = 1'b1  // 1: write changed nibbles only
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  seg_bus,
    input  logic [7:0]  seg_in,
    output logic [7:0]  seg_q,
    output logic [7:0]  digit_sel,
    output logic        busy
);

    typedef enum logic {
        SCAN  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    // Register state (q) and its next value (d)
    state_t      state_q, state_d;
    logic [2:0]  scan_pos_q, scan_pos_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [31:0] shadow_q, shadow_d;        // last word fully written to the display
    logic        shadow_vld_q, shadow_vld_d;
    logic [31:0] wbuf_q, wbuf_d;            // word being written
    logic [7:0]  mask_q, mask_d;            // nibbles of wbuf still to be written
    logic [7:0]  seg_bus_q, seg_bus_d;
    logic [7:0]  seg_q_q, seg_q_d;
    logic [7:0]  digit_sel_q, digit_sel_d;
    logic        wr_ready_q, wr_ready_d;
    logic        busy_q, busy_d;

    // Combinational helpers
    logic [7:0]  dirty;
    logic        accept;
    logic [2:0]  idx;

    // Index of the lowest set bit; the caller guarantees m is non-zero
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Load command for nibble p of word w
    function automatic logic [7:0] load_cmd(input logic [31:0] w, input logic [2:0] p);
        return {p, 1'b1, w[4*p +: 4]};
    endfunction

    // Dirty mask of the offered word against what the display already holds
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dirty[i] = !shadow_vld_q || !SKIP_UNCHANGED ||
                       (wr_data[4*i +: 4] != shadow_q[4*i +: 4]);
        end
    end

    assign accept = (state_q == SCAN) && wr_valid && wr_ready_q;

    // Next-state and next-output logic for the SCAN/WRITE controller
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path can leave a variable unassigned and infer a latch.
        state_d      = state_q;
        scan_pos_d   = scan_pos_q;
        div_cnt_d    = div_cnt_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        wbuf_d       = wbuf_q;
        mask_d       = mask_q;
        seg_bus_d    = seg_bus_q;
        seg_q_d      = seg_q_q;
        digit_sel_d  = digit_sel_q;
        wr_ready_d   = wr_ready_q;
        busy_d       = busy_q;
        idx          = 3'd0;

        case (state_q)
            SCAN: begin
                wr_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    wbuf_d = wr_data;
                end
                if (accept && (dirty != 8'h00)) begin
                    // First load cycle goes out right away. The scan counters
                    // freeze, so the display keeps its current digit.
                    idx        = lowest_set(dirty);
                    mask_d     = dirty & ~(8'h01 << idx);
                    seg_bus_d  = load_cmd(wr_data, idx);
                    state_d    = WRITE;
                    wr_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    if (div_cnt_q == DIV_LAST) begin
                        // Address has been stable for SCAN_DIV cycles: latch it
                        seg_q_d     = seg_in;
                        digit_sel_d = 8'h01 << scan_pos_q;
                        scan_pos_d  = scan_pos_q + 3'd1;
                        div_cnt_d   = 8'd0;
                    end else begin
                        div_cnt_d   = div_cnt_q + 8'd1;
                    end
                    seg_bus_d = {scan_pos_d, 1'b0, 4'h0};
                end
            end

            WRITE: begin
                if (mask_q != 8'h00) begin
                    idx       = lowest_set(mask_q);
                    mask_d    = mask_q & ~(8'h01 << idx);
                    seg_bus_d = load_cmd(wbuf_q, idx);
                end else begin
                    // Last load went out in the previous cycle; resume scanning
                    shadow_d     = wbuf_q;
                    shadow_vld_d = 1'b1;
                    state_d      = SCAN;
                    wr_ready_d   = 1'b1;
                    busy_d       = 1'b0;
                    seg_bus_d    = {scan_pos_q, 1'b0, 4'h0};
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge.
        if (!rst_n) begin
            state_q      <= SCAN;
            scan_pos_q   <= 3'd0;
            div_cnt_q    <= 8'd0;
            shadow_q     <= 32'h0;
            shadow_vld_q <= 1'b0;
            wbuf_q       <= 32'h0;
            mask_q       <= 8'h00;
            seg_bus_q    <= 8'h00;
            seg_q_q      <= 8'h00;
            digit_sel_q  <= 8'h00;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_pos_q   <= scan_pos_d;
            div_cnt_q    <= div_cnt_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            wbuf_q       <= wbuf_d;
            mask_q       <= mask_d;
            seg_bus_q    <= seg_bus_d;
            seg_q_q      <= seg_q_d;
            digit_sel_q  <= digit_sel_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign seg_bus   = seg_bus_q;
    assign seg_q     = seg_q_q;
    assign digit_sel = digit_sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_bus_writer.sv
// Testbench for seg_bus_writer (SCAN_DIV=4, SKIP_UNCHANGED=1).
// The reference model tracks the last word fully written to the display. From
// that word it lists the (position, nibble) loads that each new word must
// produce. The segment register is modelled as returning 8'hC0 + position.
module tb_seg_bus_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  seg_bus;
    logic [7:0]  seg_in;
    logic [7:0]  seg_q;
    logic [7:0]  digit_sel;
    logic        busy;

    seg_bus_writer #(.SCAN_DIV(4), .SKIP_UNCHANGED(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .seg_bus   (seg_bus),
        .seg_in    (seg_in),
        .seg_q     (seg_q),
        .digit_sel (digit_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Segment register model: returns a byte that identifies the addressed position
    assign seg_in = 8'hC0 + {5'd0, seg_bus[7:5]};

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_shadow = 32'h0;
    bit          m_vld = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected load commands for word w, then record w as displayed
    function automatic void model_loads(input logic [31:0] w);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (!m_vld || (w[4*i +: 4] != m_shadow[4*i +: 4]))
                exp_q.push_back({3'(i), 1'b1, w[4*i +: 4]});
        end
        m_shadow = w;
        m_vld    = 1'b1;
    endfunction

    // Record seg_bus for every busy cycle; count cycles where wr_ready is not low
    task automatic collect_loads(output int ready_bad);
        int n;
        got_q.delete();
        ready_bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 32) begin
            got_q.push_back(seg_bus);
            if (wr_ready !== 1'b0) ready_bad++;
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: wr_ready=%b expected 1", name, wr_ready);
        end
    endtask

    // Present one word, then check the load sequence against the model
    task automatic write_word(input logic [31:0] w, input string name);
        int rb;
        wait_ready(name);
        wr_data  = w;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        wr_data  = $urandom();
        model_loads(w);
        collect_loads(rb);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s load_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s load[%0d]: got %h expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rb != 0) begin
            errors++;
            $display("FAIL %s ready_during_write: %0d cycles with wr_ready high, expected 0", name, rb);
        end
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || seg_bus[4] !== 1'b0) begin
            errors++;
            $display("FAIL %s after_write: wr_ready=%b busy=%b load=%b expected 1 0 0",
                     name, wr_ready, busy, seg_bus[4]);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (seg_bus !== 8'h00) begin errors++; $display("FAIL reset seg_bus: got %h expected 00", seg_bus); end
        checks++;
        if (seg_q !== 8'h00) begin errors++; $display("FAIL reset seg_q: got %h expected 00", seg_q); end
        checks++;
        if (digit_sel !== 8'h00) begin errors++; $display("FAIL reset digit_sel: got %h expected 00", digit_sel); end
        checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset ready_busy: got %b%b expected 00", wr_ready, busy);
        end
        rst_n = 1'b1;
        m_vld = 1'b0;
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release wr_ready: got %b expected 1", wr_ready); end
        checks++;
        if (seg_bus !== 8'h00) begin errors++; $display("FAIL reset_release seg_bus: got %h expected 00", seg_bus); end
    endtask

    task automatic test_first_write();
        logic [7:0] t2 [8];
        t2 = '{8'h1F, 8'h3E, 8'h5D, 8'h7C, 8'h9B, 8'hBA, 8'hD9, 8'hF8};
        write_word(32'h89ABCDEF, "first_write");
        checks++;
        if (got_q.size() != 8) begin
            errors++; $display("FAIL first_write_literal count: got %0d expected 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== t2[i]) begin
                    errors++; $display("FAIL first_write_literal[%0d]: got %h expected %h", i, got_q[i], t2[i]);
                end
            end
        end
    endtask

    task automatic test_skip_unchanged();
        write_word(32'h89AB0DEF, "skip_one");
        write_word(32'h89AB0DEF, "skip_none");
    endtask

    // Free-running scan: a new digit every 4 cycles, wrapping 7 -> 0
    task automatic test_scan();
        logic [7:0] prev;
        int exp_pos, n, len;
        prev = digit_sel;
        n = 0;
        while (digit_sel === prev && n < 64) begin tick(); n++; end
        exp_pos = 0;
        for (int i = 0; i < 8; i++) if (digit_sel[i]) exp_pos = i;
        for (int t = 0; t < 10; t++) begin
            prev = digit_sel;
            len  = 0;
            while (digit_sel === prev && len < 16) begin
                if (seg_bus[4] !== 1'b0) begin
                    errors++; $display("FAIL scan load_asserted: seg_bus=%h expected load 0", seg_bus);
                end
                tick();
                len++;
            end
            exp_pos = (exp_pos + 1) % 8;
            checks++;
            if (len != 4) begin errors++; $display("FAIL scan period: got %0d expected 4", len); end
            checks++;
            if (digit_sel !== (8'h01 << exp_pos)) begin
                errors++; $display("FAIL scan digit_sel: got %h expected %h", digit_sel, 8'h01 << exp_pos);
            end
            checks++;
            if (seg_q !== 8'(8'hC0 + exp_pos)) begin
                errors++; $display("FAIL scan seg_q: got %h expected %h", seg_q, 8'(8'hC0 + exp_pos));
            end
            checks++;
            if (seg_bus !== {3'(exp_pos + 1), 5'b0}) begin
                errors++; $display("FAIL scan seg_bus: got %h expected %h", seg_bus, {3'(exp_pos + 1), 5'b0});
            end
        end
    endtask

    // Accept a word while position 5 is on its third cycle
    task automatic test_write_during_scan();
        int n, hold_bad;
        logic [31:0] w;
        n = 0;
        while (seg_bus[7:5] !== 3'd4 && n < 64) begin tick(); n++; end
        while (seg_bus[7:5] !== 3'd5 && n < 128) begin tick(); n++; end
        checks++;
        if (seg_bus[7:5] !== 3'd5) begin errors++; $display("FAIL mid_scan sync: pos %0d expected 5", seg_bus[7:5]); end
        tick();
        tick();
        w        = ~m_shadow;
        wr_data  = w;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        model_loads(w);
        got_q.delete();
        hold_bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 32) begin
            got_q.push_back(seg_bus);
            if (digit_sel !== 8'h10 || seg_q !== 8'hC4) hold_bad++;
            tick();
            n++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL mid_scan hold: %0d bad cycles expected 0", hold_bad); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL mid_scan load_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL mid_scan load[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (seg_bus !== 8'hA0 || digit_sel !== 8'h10) begin
            errors++; $display("FAIL mid_scan resume: seg_bus=%h digit_sel=%h expected A0 10", seg_bus, digit_sel);
        end
        tick();
        checks++;
        if (seg_bus !== 8'hA0 || digit_sel !== 8'h10) begin
            errors++; $display("FAIL mid_scan remain: seg_bus=%h digit_sel=%h expected A0 10", seg_bus, digit_sel);
        end
        tick();
        checks++;
        if (seg_bus !== 8'hC0 || digit_sel !== 8'h20 || seg_q !== 8'hC5) begin
            errors++; $display("FAIL mid_scan advance: seg_bus=%h digit_sel=%h seg_q=%h expected C0 20 C5",
                               seg_bus, digit_sel, seg_q);
        end
    endtask

    // Random words: fresh values, repeats, and single-nibble changes
    task automatic test_random();
        logic [31:0] w;
        int mode, p;
        for (int k = 0; k < 24; k++) begin
            mode = $urandom_range(0, 2);
            w    = m_shadow;
            if (mode == 0) w = $urandom();
            else if (mode == 2) begin
                p = $urandom_range(0, 7);
                w[4*p +: 4] = w[4*p +: 4] ^ 4'(1 + $urandom_range(0, 14));
            end
            write_word(w, "random");
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    // Reset after the third load of a full write; the next write resends all nibbles
    task automatic test_reset_mid_write();
        logic [31:0] w;
        logic [7:0]  e;
        write_word(32'h76543210, "pre_abort");
        w = 32'h89ABCDEF;
        wait_ready("abort");
        wr_data  = w;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = {3'(k), 1'b1, w[4*k +: 4]};
            checks++;
            if (seg_bus !== e) begin errors++; $display("FAIL abort load[%0d]: got %h expected %h", k, seg_bus, e); end
            if (k < 2) tick();
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (seg_bus !== 8'h00 || busy !== 1'b0 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL abort reset: seg_bus=%h busy=%b wr_ready=%b expected 00 0 0",
                               seg_bus, busy, wr_ready);
        end
        rst_n    = 1'b1;
        m_vld    = 1'b0;
        m_shadow = 32'h0;
        tick();
        write_word(w, "after_abort");
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_skip_unchanged();
        test_scan();
        test_write_during_scan();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
